inst_fetch_unit: RTL and testbench

//  Instruction-fetch initiator for the instruction ROM port: owns the fetch PC, drives rom_en/rom_addr,

---
 rtl/inst_fetch_unit_pkg.sv | 43 ++++
 rtl/inst_fetch_unit_if.sv | 48 ++++
 rtl/inst_fetch_unit_ifu_fifo.sv | 91 +++++++++
 rtl/inst_fetch_unit.sv | 125 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_pkg
// Shared constants and types for the instruction fetch unit and its prefetch
// FIFO. Defines the zero/NOP instruction word, the PC increment, address and
// instruction widths, the alignment mask, the buffered entry layout and the
// fetch-state enum.
// Ports: none (package).
// Optional feature macro used by the top: IFU_PERF_CNT_EN.
// -----------------------------------------------------------------------------
package inst_fetch_unit_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  // Word presented to decode when nothing is buffered
  localparam logic [INST_W-1:0] NOP_INST = '0;

  // Byte distance between consecutive instruction words
  localparam logic [ADDR_W-1:0] PC_INCR = 32'd4;

  // Clears the two byte-offset bits so every fetch is word aligned
  localparam logic [ADDR_W-1:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

  // One prefetch entry: PC in the upper half, instruction in the lower half
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // The fetcher idles for exactly one edge after reset release, then runs
  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

  // Word-aligns an arbitrary byte address
  function automatic logic [ADDR_W-1:0] alignWord(input logic [ADDR_W-1:0] addr);
    return addr & ADDR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_if
// Bundles the fetch unit's ROM port, redirect inputs and decode handshake.
// Modport master is the fetch unit itself; modport slave is its environment
// (ROM, execute redirect logic and the decode stage).
//   rom_en_o / rom_addr_o   fetch request and word-aligned byte address
//   rom_inst_i              same-cycle combinational instruction word
//   jump_en_i / jump_addr_i redirect request and target byte address
//   inst_valid_o / inst_ready_i  decode handshake
//   inst_o / inst_pc_o      head instruction word and its PC
// -----------------------------------------------------------------------------
interface inst_fetch_unit_if;

  logic        rom_en_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  modport master (
    output rom_en_o,
    output rom_addr_o,
    input  rom_inst_i,
    input  jump_en_i,
    input  jump_addr_i,
    output inst_valid_o,
    input  inst_ready_i,
    output inst_o,
    output inst_pc_o
  );

  modport slave (
    input  rom_en_o,
    input  rom_addr_o,
    output rom_inst_i,
    output jump_en_i,
    output jump_addr_i,
    input  inst_valid_o,
    output inst_ready_i,
    input  inst_o,
    input  inst_pc_o
  );

endinterface

// File: rtl/inst_fetch_unit_ifu_fifo.sv
// -----------------------------------------------------------------------------
// ifu_fifo
// Synchronous circular-buffer FIFO used as the fetch unit's prefetch buffer.
// Flush has priority over push and pop. Push while full and pop while empty
// are ignored. data_o shows the raw head slot; callers gate it with count/empty.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   flush_i          discard all entries (pointers and count to zero)
//   push_i, data_i   write an entry
//   pop_i            advance the head
//   data_o           head entry
//   count_o          number of stored entries (0..DEPTH)
//   full_o, empty_o  registered status flags
// -----------------------------------------------------------------------------
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  // A flush swallows any push or pop requested in the same cycle
  assign doPush = push_i & ~full_o  & ~flush_i;
  assign doPop  = pop_i  & ~empty_o & ~flush_i;

  // Next-state pointers and occupancy; DEPTH is a power of two so the
  // pointers wrap on their natural overflow
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset because reads are gated by count
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// Instruction-fetch initiator between the instruction ROM and the IF/ID
// register. Owns the fetch PC, issues one ROM read per cycle while the
// prefetch buffer has room, captures the same-cycle ROM word together with its
// PC, and hands entries to decode over a valid/ready handshake. A redirect
// flushes the buffer and restarts fetch at the word-aligned target.
// Parameters:
//   RESET_PC    fetch address after reset (word aligned)
//   FIFO_DEPTH  prefetch entries (power of two, >= 2)
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   ifc         inst_fetch_unit_if.master (ROM port, redirect, decode handshake)
//   perf_fetch_cnt_o, perf_stall_cnt_o  only when IFU_PERF_CNT_EN is defined:
//               pushes into the buffer and cycles decode held a valid head
// -----------------------------------------------------------------------------
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inst_fetch_unit_if.master     ifc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt_o,
  output logic [31:0]           perf_stall_cnt_o
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetchPc_q, fetchPc_d;
  logic              romEn;
  logic              instValid;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CNT_W-1:0]  fifoCount;
  logic              headLive;
  fetch_entry_t      pushEntry;
  fetch_entry_t      headEntry;

  // Fetch only when running, not redirecting and the registered count says
  // there is room. A pop in the same cycle deliberately does not open a slot,
  // keeping decode's ready off the path to the ROM enable.
  assign romEn     = (state_q == FETCH_RUN) & ~fifoFull & ~ifc.jump_en_i;
  assign instValid = ~fifoEmpty & ~ifc.jump_en_i;
  assign headLive  = (fifoCount != '0);

  assign pushEntry.pc   = fetchPc_q;
  assign pushEntry.inst = ifc.rom_inst_i;

  assign ifc.rom_en_o     = romEn;
  assign ifc.rom_addr_o   = fetchPc_q;
  assign ifc.inst_valid_o = instValid;
  assign ifc.inst_o       = headLive ? headEntry.inst : NOP_INST;
  assign ifc.inst_pc_o    = headLive ? headEntry.pc   : '0;

  // Redirect wins over sequential advance; low address bits of the target
  // are dropped rather than faulted
  always_comb begin
    fetchPc_d = fetchPc_q;
    if (ifc.jump_en_i) begin
      fetchPc_d = alignWord(ifc.jump_addr_i);
    end else if (romEn) begin
      fetchPc_d = fetchPc_q + PC_INCR;
    end
  end

  // Fetch state machine: one idle edge after reset release, then run;
  // the PC register moves alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH_IDLE;
      fetchPc_q <= RESET_PC;
    end else begin
      case (state_q)
        FETCH_IDLE: state_q <= FETCH_RUN;
        FETCH_RUN:  state_q <= FETCH_RUN;
        default:    state_q <= FETCH_IDLE;
      endcase
      fetchPc_q <= fetchPc_d;
    end
  end

  // Prefetch buffer; a redirect flushes it and blocks push/pop that cycle
  ifu_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (ifc.jump_en_i),
    .push_i  (romEn),
    .pop_i   (instValid & ifc.inst_ready_i),
    .data_i  (pushEntry),
    .data_o  (headEntry),
    .count_o (fifoCount),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perfFetchCnt_q;
  logic [31:0] perfStallCnt_q;

  // Free-running wrap-around counters of buffer pushes and decode stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfFetchCnt_q <= '0;
      perfStallCnt_q <= '0;
    end else begin
      if (romEn) perfFetchCnt_q <= perfFetchCnt_q + 32'd1;
      if (instValid & ~ifc.inst_ready_i) perfStallCnt_q <= perfStallCnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = perfFetchCnt_q;
  assign perf_stall_cnt_o = perfStallCnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
// Directed scenarios followed by randomized traffic for inst_fetch_unit.
// Expected outputs come from a queue-based model of the fetch unit's rules.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic [31:0] romSalt = 32'h0;

  int checks = 0;
  int errors = 0;

  inst_fetch_unit_if ifc();

  // ROM emulation: the word stored at an address is that address xor a salt
  assign ifc.rom_inst_i = ifc.rom_addr_o ^ romSalt;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perfFetch;
  logic [31:0] perfStall;
`endif

  inst_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ifc   (ifc)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt_o (perfFetch),
    .perf_stall_cnt_o (perfStall)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: pending entries as {pc, inst}, fetch pointer, run flag
  logic [63:0] modelQ[$];
  logic [31:0] modelPc;
  bit          modelRun;
  logic [31:0] modelFetchCnt;
  logic [31:0] modelStallCnt;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with what the model predicts for the current inputs
  task automatic checkOutput(input string phase);
    logic        expValid;
    logic        expRomEn;
    logic [31:0] expInst;
    logic [31:0] expPc;
    expValid = (modelQ.size() != 0) && !ifc.jump_en_i;
    expRomEn = modelRun && (modelQ.size() < DEPTH) && !ifc.jump_en_i;
    expInst  = (modelQ.size() != 0) ? modelQ[0][31:0]  : 32'h0;
    expPc    = (modelQ.size() != 0) ? modelQ[0][63:32] : 32'h0;
    check1 ({phase, ".inst_valid"}, ifc.inst_valid_o, expValid);
    check1 ({phase, ".rom_en"},     ifc.rom_en_o,     expRomEn);
    check32({phase, ".rom_addr"},   ifc.rom_addr_o,   modelPc);
    check32({phase, ".inst"},       ifc.inst_o,       expInst);
    check32({phase, ".inst_pc"},    ifc.inst_pc_o,    expPc);
`ifdef IFU_PERF_CNT_EN
    check32({phase, ".perf_fetch"}, perfFetch, modelFetchCnt);
    check32({phase, ".perf_stall"}, perfStall, modelStallCnt);
`endif
  endtask

  // Drive one cycle of inputs, check, then advance the model across the edge.
  // Entered and left at 1 time unit after a rising edge.
  task automatic applyStimulus(input string phase, input logic j,
                               input logic [31:0] ja, input logic rdy);
    bit v;
    bit en;
    ifc.jump_en_i    = j;
    ifc.jump_addr_i  = ja;
    ifc.inst_ready_i = rdy;
    #4;
    checkOutput(phase);
    v  = (modelQ.size() != 0) && !j;
    en = modelRun && (modelQ.size() < DEPTH) && !j;
    if (v && !rdy) modelStallCnt++;
    if (j) begin
      modelQ.delete();
      modelPc = ja & 32'hFFFF_FFFC;
    end else begin
      if (v && rdy) void'(modelQ.pop_front());
      if (en) begin
        modelQ.push_back({modelPc, modelPc ^ romSalt});
        modelPc = modelPc + 32'd4;
        modelFetchCnt++;
      end
    end
    modelRun = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must react at once
  task automatic doReset(input string phase);
    #2;
    rst_n            = 1'b0;
    ifc.jump_en_i    = 1'b0;
    ifc.jump_addr_i  = 32'h0;
    ifc.inst_ready_i = 1'b0;
    modelQ.delete();
    modelPc       = RESET_PC;
    modelRun      = 1'b0;
    modelFetchCnt = 32'h0;
    modelStallCnt = 32'h0;
    #1;
    checkOutput(phase);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    ifc.jump_en_i    = 1'b0;
    ifc.jump_addr_i  = 32'h0;
    ifc.inst_ready_i = 1'b0;

    // Scenario 1: free-flowing fetch, ROM word equals address
    doReset("s1_rst");
    for (int i = 0; i < 8; i++) applyStimulus("s1", 1'b0, 32'h0, 1'b1);

    // Scenario 2: decode stalled from the start, buffer fills to DEPTH
    doReset("s2_rst");
    for (int i = 0; i < 7; i++) applyStimulus("s2", 1'b0, 32'h0, 1'b0);
    check1 ("s2_full_no_fetch", ifc.rom_en_o,  1'b0);
    check32("s2_head_pc",       ifc.inst_pc_o, 32'h0);
`ifdef IFU_PERF_CNT_EN
    check32("s2_perf_fetch", perfFetch, 32'd4);
    check32("s2_perf_stall", perfStall, 32'd5);
`endif

    // Scenario 3: single pop while full gives a bubble, then fetch of 0x10
    applyStimulus("s3_pop", 1'b0, 32'h0, 1'b1);
    check1 ("s3_fetch_resumes", ifc.rom_en_o,   1'b1);
    check32("s3_fetch_addr",    ifc.rom_addr_o, 32'h10);
    check32("s3_new_head",      ifc.inst_pc_o,  32'h4);

    // Scenario 4: redirect to a misaligned target with 3 entries buffered
    doReset("s4_rst");
    for (int i = 0; i < 4; i++) applyStimulus("s4_fill", 1'b0, 32'h0, 1'b0);
    applyStimulus("s4_jump", 1'b1, 32'h0000_0103, 1'b1);
    check32("s4_target_addr", ifc.rom_addr_o, 32'h100);
    check1 ("s4_flushed",     ifc.inst_valid_o, 1'b0);
    applyStimulus("s4_run", 1'b0, 32'h0, 1'b1);
    check32("s4_first_pc", ifc.inst_pc_o, 32'h100);
    for (int i = 0; i < 3; i++) applyStimulus("s4_run", 1'b0, 32'h0, 1'b1);

    // Scenario 5: fetch PC wraps through the top of the address space
    applyStimulus("s5_jump", 1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus("s5_run", 1'b0, 32'h0, 1'b1);
    check32("s5_wrapped_pc", ifc.inst_pc_o, 32'h0000_0000);
    applyStimulus("s5_run", 1'b0, 32'h0, 1'b1);

    // Back-to-back redirects: only the last target is fetched
    applyStimulus("bb_jump1", 1'b1, 32'h0000_2000, 1'b1);
    applyStimulus("bb_jump2", 1'b1, 32'h0000_3006, 1'b1);
    check32("bb_last_wins", ifc.rom_addr_o, 32'h3004);
    applyStimulus("bb_run", 1'b0, 32'h0, 1'b1);

    // Scenario 6: asynchronous reset mid-stream, then restart
    for (int i = 0; i < 3; i++) applyStimulus("s6_pre", 1'b0, 32'h0, 1'b0);
    doReset("s6_rst");
    for (int i = 0; i < 4; i++) applyStimulus("s6_post", 1'b0, 32'h0, 1'b1);

    // Randomized traffic: stalls, redirects (some near the wrap point),
    // ROM content changes and occasional resets
    for (int i = 0; i < 400; i++) begin
      logic        j;
      logic [31:0] ja;
      logic        rdy;
      if ($urandom_range(0, 99) < 2) begin
        doReset("rnd_rst");
      end else begin
        if ($urandom_range(0, 19) == 0) romSalt = $urandom();
        j   = ($urandom_range(0, 15) == 0);
        ja  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                          : $urandom();
        rdy = ($urandom_range(0, 3) != 0);
        applyStimulus("rnd", j, ja, rdy);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
